// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings, FSM state encoding and datapath
//               defaults for the ALU execute stage and its decode/control.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned c_ALU_WIDTH = 32;
    localparam int unsigned c_OP_W      = 7;

    localparam logic [c_OP_W-1:0] c_OP_ADD  = 7'h00;
    localparam logic [c_OP_W-1:0] c_OP_SUB  = 7'h01;
    localparam logic [c_OP_W-1:0] c_OP_AND  = 7'h02;
    localparam logic [c_OP_W-1:0] c_OP_OR   = 7'h03;
    localparam logic [c_OP_W-1:0] c_OP_XOR  = 7'h04;
    localparam logic [c_OP_W-1:0] c_OP_NOT  = 7'h05;
    localparam logic [c_OP_W-1:0] c_OP_TWOS = 7'h06;
    localparam logic [c_OP_W-1:0] c_OP_SLL  = 7'h07;
    localparam logic [c_OP_W-1:0] c_OP_SRL  = 7'h08;
    localparam logic [c_OP_W-1:0] c_OP_SRA  = 7'h09;
    localparam logic [c_OP_W-1:0] c_OP_COMP = 7'h0A;
    localparam logic [c_OP_W-1:0] c_OP_MUL  = 7'h0B;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_MUL   = 3'd3,
        ST_DONE  = 3'd4
    } alu_state_t;

    function automatic logic is_shift_op(input logic [c_OP_W-1:0] op);
        return (op == c_OP_SLL) || (op == c_OP_SRL) || (op == c_OP_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_serial.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_serial
// Description : Radix-2 unsigned shift-add multiplier, one iteration per step.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_serial #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int c_CNT_W = $clog2(MUL_STEPS + 1);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_step;

    // Upper half accumulates; lower half starts as the multiplier and drains out.
    assign w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                       + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_prod_step = {w_sum, r_prod[WIDTH-1:1]};

    // Product is presented as the post-step value so the caller can capture it with done.
    assign done    = step && (r_cnt == c_CNT_W'(MUL_STEPS - 1));
    assign product = step ? w_prod_step : r_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
        end else if (start) begin
            r_mcand <= multiplicand;
            r_prod  <= {{WIDTH{1'b0}}, multiplier};
            r_cnt   <= '0;
        end else if (step) begin
            r_prod  <= w_prod_step;
            r_cnt   <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute stage with start/busy/done handshake; single-cycle
//               logic/arithmetic, bit-serial shifts and serial multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH     = c_ALU_WIDTH,
    parameter int MUL_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        aluOp,
    input  logic [WIDTH-1:0]  input1,
    input  logic [WIDTH-1:0]  input2,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_hi,
    output logic              zero,
    output logic              sign,
    output logic              carry,
    output logic              overflow,
    output logic              illegal_op
);

    localparam int c_SHAMT_W = $clog2(WIDTH);

    alu_state_t           r_state;
    alu_state_t           w_state_next;
    logic [6:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_shreg;
    logic [c_SHAMT_W-1:0] r_cnt;

    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_result_hi;
    logic                 r_zero;
    logic                 r_sign;
    logic                 r_carry;
    logic                 r_overflow;
    logic                 r_illegal;

    logic [c_SHAMT_W-1:0] w_amt;
    logic                 w_is_shift;
    logic                 w_accept;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_carry;
    logic                 w_alu_ovf;
    logic                 w_alu_ill;
    logic [WIDTH-1:0]     w_sh_next;
    logic                 w_sh_out;
    logic                 w_mul_start;
    logic                 w_mul_step;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_mul_prod;

    logic                 w_load;
    logic [WIDTH-1:0]     w_res_d;
    logic [WIDTH-1:0]     w_hi_d;
    logic                 w_carry_d;
    logic                 w_ovf_d;
    logic                 w_ill_d;

    assign w_amt      = r_b[c_SHAMT_W-1:0];
    assign w_is_shift = is_shift_op(r_op);
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_add      = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub      = {1'b0, r_a} + {1'b0, ~r_b} + (WIDTH+1)'(1);

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        w_alu_ill   = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_alu_res   = w_add[WIDTH-1:0];
                w_alu_carry = w_add[WIDTH];
                w_alu_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_alu_res   = w_sub[WIDTH-1:0];
                w_alu_carry = w_sub[WIDTH];
                w_alu_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_OP_AND:  w_alu_res = r_a & r_b;
            c_OP_OR:   w_alu_res = r_a | r_b;
            c_OP_XOR:  w_alu_res = r_a ^ r_b;
            c_OP_NOT:  w_alu_res = ~r_a;
            c_OP_TWOS: w_alu_res = -r_a;
            c_OP_COMP: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            c_OP_SLL, c_OP_SRL, c_OP_SRA, c_OP_MUL: w_alu_res = '0;
            default:   w_alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_sh_next = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
        w_sh_out  = r_shreg[0];
        case (r_op)
            c_OP_SLL: begin
                w_sh_next = {r_shreg[WIDTH-2:0], 1'b0};
                w_sh_out  = r_shreg[WIDTH-1];
            end
            c_OP_SRL: w_sh_next = {1'b0, r_shreg[WIDTH-1:1]};
            default:  ;
        endcase
    end

    assign w_mul_start = (r_state == ST_EXEC) && (r_op == c_OP_MUL);
    assign w_mul_step  = (r_state == ST_MUL);

    alu_mul_serial #(
        .WIDTH     (WIDTH),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (w_mul_start),
        .step         (w_mul_step),
        .multiplicand (r_a),
        .multiplier   (r_b),
        .done         (w_mul_done),
        .product      (w_mul_prod)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_EXEC;
            ST_EXEC: begin
                if (r_op == c_OP_MUL)                 w_state_next = ST_MUL;
                else if (w_is_shift && (w_amt != '0)) w_state_next = ST_SHIFT;
                else                                  w_state_next = ST_DONE;
            end
            ST_SHIFT: if (r_cnt == c_SHAMT_W'(1)) w_state_next = ST_DONE;
            ST_MUL:   if (w_mul_done) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Visible outputs are only loaded on the transition into DONE.
    always_comb begin
        w_load    = 1'b0;
        w_res_d   = '0;
        w_hi_d    = '0;
        w_carry_d = 1'b0;
        w_ovf_d   = 1'b0;
        w_ill_d   = 1'b0;
        case (r_state)
            ST_EXEC: begin
                if (w_is_shift && (w_amt == '0)) begin
                    w_load  = 1'b1;
                    w_res_d = r_a;
                end else if (!w_is_shift && (r_op != c_OP_MUL)) begin
                    w_load    = 1'b1;
                    w_res_d   = w_alu_res;
                    w_carry_d = w_alu_carry;
                    w_ovf_d   = w_alu_ovf;
                    w_ill_d   = w_alu_ill;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_SHAMT_W'(1)) begin
                    w_load    = 1'b1;
                    w_res_d   = w_sh_next;
                    w_carry_d = w_sh_out;
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_load  = 1'b1;
                    w_res_d = w_mul_prod[WIDTH-1:0];
                    w_hi_d  = w_mul_prod[2*WIDTH-1:WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_sign      <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= aluOp;
                r_a       <= input1;
                r_b       <= input2;
                r_illegal <= 1'b0;
            end
            if (r_state == ST_EXEC) begin
                r_shreg <= r_a;
                r_cnt   <= w_amt;
            end else if (r_state == ST_SHIFT) begin
                r_shreg <= w_sh_next;
                r_cnt   <= r_cnt - c_SHAMT_W'(1);
            end
            if (w_load) begin
                r_result    <= w_res_d;
                r_result_hi <= w_hi_d;
                r_zero      <= (w_res_d == '0);
                r_sign      <= w_res_d[WIDTH-1];
                r_carry     <= w_carry_d;
                r_overflow  <= w_ovf_d;
                r_illegal   <= w_ill_d;
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign result     = r_result;
    assign result_hi  = r_result_hi;
    assign zero       = r_zero;
    assign sign       = r_sign;
    assign carry      = r_carry;
    assign overflow   = r_overflow;
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  aluOp;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        sign;
    logic        carry;
    logic        overflow;
    logic        illegal_op;

    int n_total;
    int n_pass;
    int n_fail;

    alu_exec_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .aluOp      (aluOp),
        .input1     (input1),
        .input2     (input2),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_hi  (result_hi),
        .zero       (zero),
        .sign       (sign),
        .carry      (carry),
        .overflow   (overflow),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, optionally poke start mid-flight, then check latency and outputs.
    task automatic do_op(input string tag, input logic [6:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int poke, input int exp_lat,
                         input logic [31:0] exp_res, input logic [31:0] exp_hi,
                         input logic exp_c, input logic exp_v, input logic exp_ill);
        int lat;
        @(negedge clk);
        aluOp  = op;
        input1 = a;
        input2 = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        aluOp  = c_OP_MUL;
        input1 = 32'hDEAD_BEEF;
        input2 = 32'h0000_001F;
        lat    = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check($sformatf("%s.ill_clr", tag), illegal_op, 1'b0);
            if (poke != 0 && lat == poke) begin
                aluOp  = c_OP_ADD;
                input1 = 32'h1;
                input2 = 32'h1;
                start  = 1'b1;
            end
            if (poke != 0 && lat == poke + 2) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        check($sformatf("%s.lat", tag), lat, exp_lat);
        check($sformatf("%s.busy", tag), busy, 1'b1);
        check($sformatf("%s.res", tag), result, exp_res);
        check($sformatf("%s.hi", tag), result_hi, exp_hi);
        check($sformatf("%s.carry", tag), carry, exp_c);
        check($sformatf("%s.ovf", tag), overflow, exp_v);
        check($sformatf("%s.zero", tag), zero, exp_res == 32'h0);
        check($sformatf("%s.sign", tag), sign, exp_res[31]);
        check($sformatf("%s.ill", tag), illegal_op, exp_ill);
    endtask

    initial begin
        int dones;
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        aluOp   = '0;
        input1  = '0;
        input2  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.res", result, 32'h0);
        check("rst.hi", result_hi, 32'h0);
        check("rst.flags", {zero, sign, carry, overflow, illegal_op}, 5'b0);

        //            tag      op         A             B          poke lat res           hi  c     v     ill
        do_op("add_ovf",  c_OP_ADD,  32'h7FFFFFFF, 32'h00000001, 0, 2,  32'h80000000, 0, 1'b0, 1'b1, 1'b0);
        do_op("add_wrap", c_OP_ADD,  32'hFFFFFFFF, 32'h00000001, 0, 2,  32'h00000000, 0, 1'b1, 1'b0, 1'b0);
        do_op("sub_eq",   c_OP_SUB,  32'h00000005, 32'h00000005, 0, 2,  32'h00000000, 0, 1'b1, 1'b0, 1'b0);
        do_op("sub_ovf",  c_OP_SUB,  32'h80000000, 32'h00000001, 0, 2,  32'h7FFFFFFF, 0, 1'b1, 1'b1, 1'b0);
        do_op("sub_brw",  c_OP_SUB,  32'h00000002, 32'h00000003, 0, 2,  32'hFFFFFFFF, 0, 1'b0, 1'b0, 1'b0);
        do_op("comp_lt",  c_OP_COMP, 32'hFFFFFFFD, 32'h00000002, 0, 2,  32'h00000001, 0, 1'b0, 1'b0, 1'b0);
        do_op("comp_ge",  c_OP_COMP, 32'h00000002, 32'hFFFFFFFD, 0, 2,  32'h00000000, 0, 1'b0, 1'b0, 1'b0);
        do_op("and",      c_OP_AND,  32'hF0F01234, 32'h0FF0FF00, 0, 2,  32'h00F01200, 0, 1'b0, 1'b0, 1'b0);
        do_op("or",       c_OP_OR,   32'hF0F01234, 32'h0FF0FF00, 0, 2,  32'hFFF0FF34, 0, 1'b0, 1'b0, 1'b0);
        do_op("xor",      c_OP_XOR,  32'hF0F01234, 32'h0FF0FF00, 0, 2,  32'hFF00ED34, 0, 1'b0, 1'b0, 1'b0);
        do_op("not",      c_OP_NOT,  32'h0000FFFF, 32'h12345678, 0, 2,  32'hFFFF0000, 0, 1'b0, 1'b0, 1'b0);
        do_op("twos",     c_OP_TWOS, 32'h00000001, 32'h00000000, 0, 2,  32'hFFFFFFFF, 0, 1'b0, 1'b0, 1'b0);
        do_op("sra4",     c_OP_SRA,  32'h80000000, 32'h00000024, 0, 6,  32'hF8000000, 0, 1'b0, 1'b0, 1'b0);
        do_op("srl1",     c_OP_SRL,  32'h00000003, 32'hFFFFFFE1, 0, 3,  32'h00000001, 0, 1'b1, 1'b0, 1'b0);
        do_op("sll1",     c_OP_SLL,  32'h80000001, 32'h00000001, 0, 3,  32'h00000002, 0, 1'b1, 1'b0, 1'b0);
        do_op("sll0",     c_OP_SLL,  32'h12345678, 32'h00000020, 0, 2,  32'h12345678, 0, 1'b0, 1'b0, 1'b0);
        do_op("illegal",  7'h55,     32'h12345678, 32'h00000001, 0, 2,  32'h00000000, 0, 1'b0, 1'b0, 1'b1);
        do_op("mul",      c_OP_MUL,  32'hFFFFFFFF, 32'h00000002, 10, 34, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        check("mul.after_busy", busy, 1'b0);
        check("mul.after_hold", result, 32'hFFFFFFFE);

        // Reset in the middle of a long shift must drop the op silently.
        @(negedge clk);
        aluOp  = c_OP_SLL;
        input1 = 32'h00000001;
        input2 = 32'h00000014;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rstmid.dones", dones, 0);
        check("rstmid.busy", busy, 1'b0);
        check("rstmid.res", result, 32'h0);
        check("rstmid.hi", result_hi, 32'h0);
        check("rstmid.flags", {zero, sign, carry, overflow, illegal_op}, 5'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
